// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin arbitration,
// operand registers, and result/flag capture in an IDLE -> EXEC -> DONE sequence.
module alu_arbiter #(
   parameter int n = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [n-1:0] a0,
   input  logic [n-1:0] b0,
   input  logic [n-1:0] a1,
   input  logic [n-1:0] b1,
   input  logic [3:0]   ctrl0,
   input  logic [3:0]   ctrl1,
   input  logic         setf0,
   input  logic         setf1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic         busy,
   output logic [n-1:0] alu_a,
   output logic [n-1:0] alu_b,
   output logic [3:0]   alu_ctrl,
   input  logic [n-1:0] alu_result,
   input  logic         alu_z,
   input  logic         alu_n,
   input  logic         alu_v,
   input  logic         alu_c,
   output logic [n-1:0] result_q,
   output logic [3:0]   flags_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   logic   last_q;    // 1 = requester 1 won the previous arbitration
   logic   winner_q;  // requester owning the in-flight operation
   logic   setf_q;
   logic   winner_d;

   // On a tie the requester that did not win last time goes first.
   assign winner_d = (req0 && req1) ? ~last_q : req1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         winner_q <= 1'b0;
         setf_q   <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         busy     <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= 4'b0000;
         result_q <= '0;
         flags_q  <= 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q  <= EXEC;
                  last_q   <= winner_d;
                  winner_q <= winner_d;
                  setf_q   <= winner_d ? setf1 : setf0;
                  alu_a    <= winner_d ? a1 : a0;
                  alu_b    <= winner_d ? b1 : b0;
                  alu_ctrl <= winner_d ? ctrl1 : ctrl0;
                  gnt0     <= ~winner_d;
                  gnt1     <= winner_d;
                  busy     <= 1'b1;
               end
            end
            EXEC: begin
               state_q  <= DONE;
               result_q <= alu_result;
               if (setf_q) begin
                  flags_q <= {alu_n, alu_z, alu_c, alu_v};
               end
               gnt0     <= 1'b0;
               gnt1     <= 1'b0;
               done0    <= ~winner_q;
               done1    <= winner_q;
            end
            DONE: begin
               state_q <= IDLE;
               done0   <= 1'b0;
               done1   <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               gnt0    <= 1'b0;
               gnt1    <= 1'b0;
               done0   <= 1'b0;
               done1   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a cycle-count based
// transaction model with an integer-arithmetic ALU reference.
module tb_alu_arbiter;
   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1;
   logic [N-1:0] a0, b0, a1, b1;
   logic [3:0]   ctrl0, ctrl1;
   logic         setf0, setf1;
   logic         gnt0, gnt1, done0, done1, busy;
   logic [N-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_ctrl;
   logic         alu_z, alu_n, alu_v, alu_c;
   logic [N-1:0] result_q;
   logic [3:0]   flags_q;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.n(N)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ctrl0(ctrl0), .ctrl1(ctrl1),
      .setf0(setf0), .setf1(setf1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result),
      .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
      .result_q(result_q), .flags_q(flags_q)
   );

   // Shared ALU and flag generator seen by the arbiter (bit-level form).
   logic [N:0] wide;
   always_comb begin
      wide       = '0;
      alu_result = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      case (alu_ctrl)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: begin
            wide       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = wide[N-1:0];
            alu_c      = wide[N];
            alu_v      = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
         end
         4'b0110: begin
            wide       = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
            alu_result = wide[N-1:0];
            alu_c      = wide[N];
            alu_v      = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
         end
         default: alu_result = alu_a ^ alu_b;
      endcase
   end
   assign alu_z = (alu_result == '0);
   assign alu_n = alu_result[N-1];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference ALU using plain integer arithmetic; flags returned as {N,Z,C,V}.
   function automatic void ref_alu(input int a, input int b, input logic [3:0] c,
                                   output int r, output logic [3:0] f);
      int full, sa, sb, sfull, modv, half;
      logic cy, ov;
      modv = 1 << N;
      half = 1 << (N - 1);
      sa = (a >= half) ? a - modv : a;
      sb = (b >= half) ? b - modv : b;
      cy = 1'b0;
      ov = 1'b0;
      case (c)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: begin
            full  = a + b;
            cy    = (full >= modv);
            r     = full % modv;
            sfull = sa + sb;
            ov    = (sfull >= half) || (sfull < -half);
         end
         4'b0110: begin
            full  = a - b;
            cy    = (a >= b);
            r     = (full + modv) % modv;
            sfull = sa - sb;
            ov    = (sfull >= half) || (sfull < -half);
         end
         default: r = a ^ b;
      endcase
      f = {(r >= half), (r == 0), cy, ov};
   endfunction

   // Transaction model: an accepted request occupies the next two cycles
   // (grant cycle, then completion cycle) before requests are looked at again.
   int         m_left;
   int         m_last;
   int         m_win;
   int         m_a, m_b, m_res;
   logic [3:0] m_ctrl, m_flags;
   logic       m_setf;

   task automatic model_reset();
      m_left = 0; m_last = 1; m_win = 0;
      m_a = 0; m_b = 0; m_ctrl = 4'b0000; m_setf = 1'b0;
      m_res = 0; m_flags = 4'b0000;
   endtask

   task automatic model_edge();
      int r;
      logic [3:0] f;
      if (rst) begin
         model_reset();
      end else if (m_left == 0) begin
         if (req0 || req1) begin
            m_win  = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
            m_last = m_win;
            m_a    = (m_win == 1) ? int'(a1) : int'(a0);
            m_b    = (m_win == 1) ? int'(b1) : int'(b0);
            m_ctrl = (m_win == 1) ? ctrl1 : ctrl0;
            m_setf = (m_win == 1) ? setf1 : setf0;
            m_left = 2;
         end
      end else begin
         m_left--;
         if (m_left == 1) begin
            ref_alu(m_a, m_b, m_ctrl, r, f);
            m_res = r;
            if (m_setf) m_flags = f;
         end
      end
   endtask

   task automatic check_all();
      check_eq("gnt0",     32'(gnt0),     32'(m_left == 2 && m_win == 0));
      check_eq("gnt1",     32'(gnt1),     32'(m_left == 2 && m_win == 1));
      check_eq("done0",    32'(done0),    32'(m_left == 1 && m_win == 0));
      check_eq("done1",    32'(done1),    32'(m_left == 1 && m_win == 1));
      check_eq("busy",     32'(busy),     32'(m_left != 0));
      check_eq("alu_a",    32'(alu_a),    32'(m_a));
      check_eq("alu_b",    32'(alu_b),    32'(m_b));
      check_eq("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      check_eq("result_q", 32'(result_q), 32'(m_res));
      check_eq("flags_q",  32'(flags_q),  32'(m_flags));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic quiet();
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      ctrl0 = 4'b0000; ctrl1 = 4'b0000; setf0 = 1'b0; setf1 = 1'b0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   function automatic logic [3:0] rand_ctrl();
      logic [3:0] codes [4];
      codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010; codes[3] = 4'b0110;
      return codes[$urandom_range(3)];
   endfunction

   int grants[$];

   initial begin
      model_reset();
      quiet();
      do_reset();

      // Single add from requester 0 with flag update.
      req0 = 1'b1; a0 = 3'b010; b0 = 3'b001; ctrl0 = 4'b0010; setf0 = 1'b1;
      step();
      check_eq("add_gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      step();
      check_eq("add_done0", 32'(done0), 32'd1);
      check_eq("add_result", 32'(result_q), 32'd3);
      check_eq("add_nz", 32'(flags_q[3:2]), 32'd0);
      step();
      step();

      // Both requesters held for nine cycles from reset.
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      a0 = 3'd1; b0 = 3'd2; ctrl0 = 4'b0001;
      a1 = 3'd5; b1 = 3'd3; ctrl1 = 4'b0000;
      grants.delete();
      for (int i = 0; i < 9; i++) begin
         step();
         check_eq("tie_overlap", 32'(gnt0 && gnt1), 32'd0);
         if (gnt0) grants.push_back(0);
         if (gnt1) grants.push_back(1);
      end
      check_eq("tie_count", 32'(grants.size()), 32'd3);
      if (grants.size() == 3) begin
         check_eq("tie_order0", 32'(grants[0]), 32'd0);
         check_eq("tie_order1", 32'(grants[1]), 32'd1);
         check_eq("tie_order2", 32'(grants[2]), 32'd0);
      end

      // Prime flags to 0100 (zero result), then a no-setf op from requester 1.
      do_reset();
      req1 = 1'b1; a1 = 3'd0; b1 = 3'd0; ctrl1 = 4'b0010; setf1 = 1'b1;
      step(); step();
      check_eq("zero_flags", 32'(flags_q), 32'b0100);
      req1 = 1'b0;
      step();
      req1 = 1'b1; a1 = 3'd3; b1 = 3'd2; ctrl1 = 4'b0001; setf1 = 1'b0;
      step(); step();
      check_eq("nosetf_result", 32'(result_q), 32'd3);
      check_eq("nosetf_flags", 32'(flags_q), 32'b0100);
      req1 = 1'b0;
      step();

      // Requester 1 subtract to zero with setf: Z seen at its done cycle.
      req1 = 1'b1; a1 = 3'd5; b1 = 3'd5; ctrl1 = 4'b0110; setf1 = 1'b1;
      step(); step();
      check_eq("sub_done1", 32'(done1), 32'd1);
      check_eq("sub_z", 32'(flags_q[2]), 32'd1);
      req1 = 1'b0;
      step();

      // Reset in the middle of an operation aborts it.
      req0 = 1'b1; a0 = 3'd3; b0 = 3'd3; ctrl0 = 4'b0010; setf0 = 1'b1;
      step();
      rst = 1'b1; req0 = 1'b0;
      step();
      check_eq("abort_done0", 32'(done0), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_result", 32'(result_q), 32'd0);
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
      step();
      check_eq("abort_tie_gnt0", 32'(gnt0), 32'd1);
      step();
      // Drop req0 during DONE while requester 1 raises a new request.
      req0 = 1'b0; a1 = 3'd6; b1 = 3'd1; ctrl1 = 4'b0110; setf1 = 1'b0;
      step();
      step();
      check_eq("handoff_gnt1", 32'(gnt1), 32'd1);
      check_eq("handoff_a", 32'(alu_a), 32'd6);
      check_eq("handoff_b", 32'(alu_b), 32'd1);
      check_eq("handoff_ctrl", 32'(alu_ctrl), 32'b0110);
      step(); step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(39) == 0);
         req0  = $urandom_range(1);
         req1  = $urandom_range(1);
         a0    = N'($urandom); b0 = N'($urandom);
         a1    = N'($urandom); b1 = N'($urandom);
         ctrl0 = rand_ctrl(); ctrl1 = rand_ctrl();
         setf0 = $urandom_range(1); setf1 = $urandom_range(1);
         step();
         check_eq("rand_gnt_excl", 32'(gnt0 && gnt1), 32'd0);
         check_eq("rand_done_excl", 32'(done0 && done1), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
